// File: rtl/bcd_seg_scanner.sv
// bcd_seg_scanner
// Latches NUM_DIGITS BCD digits into a shadow register on a capture strobe
// and time-multiplexes them onto one common-anode seven-segment display.
// Every digit slot lasts SCAN_DIV clocks, and its first GUARD clocks are
// blanked so that the previous digit does not ghost onto the next anode.
// Codes 10..15 are shown as a dash and flagged on bad_digit.
//
// Optional build macro LEADING_ZERO_BLANK_EN: when defined, a digit k > 0 is
// blanked whenever it and all digits above it are zero. Digit 0 always shows.
// Slot timing is identical with or without the macro.
module bcd_seg_scanner #(
  parameter int NUM_DIGITS = 4,
  parameter int SCAN_DIV   = 1000,
  parameter int GUARD      = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [4*NUM_DIGITS-1:0] digits_in,
  input  logic                    capture,
  output logic [6:0]              seg_n,
  output logic [NUM_DIGITS-1:0]   an_n,
  output logic                    bad_digit
);

  localparam int TICK_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IDX_W  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(SCAN_DIV - 1);
  localparam logic [TICK_W-1:0] GUARD_T   = TICK_W'(GUARD);
  localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(NUM_DIGITS - 1);

  // Active-high gfedcba pattern; anything outside 0..9 becomes a dash.
  function automatic logic [6:0] seg_decode(input logic [3:0] d);
    logic [6:0] p;
    case (d)
      4'd0:    p = 7'h3F;
      4'd1:    p = 7'h06;
      4'd2:    p = 7'h5B;
      4'd3:    p = 7'h4F;
      4'd4:    p = 7'h66;
      4'd5:    p = 7'h6D;
      4'd6:    p = 7'h7D;
      4'd7:    p = 7'h07;
      4'd8:    p = 7'h7F;
      4'd9:    p = 7'h6F;
      default: p = 7'h40;
    endcase
    return p;
  endfunction

  // Shadow digits, scan position and registered outputs.
  logic [NUM_DIGITS-1:0][3:0] digit_q, digit_d;
  logic [TICK_W-1:0]          tick_q, tick_d;
  logic [IDX_W-1:0]           scan_q, scan_d;
  logic [NUM_DIGITS-1:0]      an_q, an_d;
  logic [6:0]                 seg_q, seg_d;
  logic                       bad_q, bad_d;

  // Per-digit leading-zero blank mask (all zero when the feature is off).
  logic [NUM_DIGITS-1:0]      lz_blank;
  logic [3:0]                 cur_digit;

  // Shadow register: level-sampled capture, independent of the scan timing.
  always_comb begin
    digit_d = digit_q;
    if (capture) begin
      digit_d = digits_in;
    end
  end

  // Prescaler and slot rotation; the slot index only moves on prescaler wrap.
  always_comb begin
    tick_d = tick_q + TICK_W'(1);
    scan_d = scan_q;
    if (tick_q == TICK_LAST) begin
      tick_d = '0;
      if (scan_q == IDX_LAST) begin
        scan_d = '0;
      end else begin
        scan_d = scan_q + IDX_W'(1);
      end
    end
  end

`ifdef LEADING_ZERO_BLANK_EN
  // Walk down from the top digit: a digit is blanked while every digit from
  // the top down to it is zero. Codes 10..15 are non-zero and stop the run.
  always_comb begin
    logic zero_run;
    zero_run = 1'b1;
    lz_blank = '0;
    for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
      zero_run    = zero_run & (digit_q[k] == 4'd0);
      lz_blank[k] = zero_run;
    end
  end
`else
  // Every digit is always displayed.
  always_comb begin
    lz_blank = '0;
  end
`endif

  // Next output word: blank during the guard interval or for a suppressed
  // leading zero, otherwise one-cold anode plus the decoded digit.
  always_comb begin
    cur_digit = digit_q[scan_q];
    an_d      = '1;
    seg_d     = 7'h7F;
    if ((tick_q >= GUARD_T) && !lz_blank[scan_q]) begin
      an_d[scan_q] = 1'b0;
      seg_d        = ~seg_decode(cur_digit);
    end
  end

  // Any shadow nibble above 9 raises the invalid-code flag.
  always_comb begin
    bad_d = 1'b0;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (digit_q[k] > 4'd9) begin
        bad_d = 1'b1;
      end
    end
  end

  // All state, including the outputs, is registered so the pins never glitch.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      digit_q <= '0;
      tick_q  <= '0;
      scan_q  <= '0;
      an_q    <= '1;
      seg_q   <= 7'h7F;
      bad_q   <= 1'b0;
    end else begin
      digit_q <= digit_d;
      tick_q  <= tick_d;
      scan_q  <= scan_d;
      an_q    <= an_d;
      seg_q   <= seg_d;
      bad_q   <= bad_d;
    end
  end

  assign an_n      = an_q;
  assign seg_n     = seg_q;
  assign bad_digit = bad_q;

endmodule

// File: doc/bcd_seg_scanner.md
Name: bcd_seg_scanner

Overview:
- Downstream display stage for the BCD up/down counter digits; consumes their 4-bit BCD outputs.
- Captures NUM_DIGITS BCD digits into a shadow register on a strobe.
- Time-multiplexes them onto one common-anode seven-segment display: rotating digit select plus a ghosting guard interval.
- Flags non-BCD codes (10-15) and shows them as a dash.

Parameters:
NUM_DIGITS, 4, digits scanned (legal 1..8)
SCAN_DIV, 1000, clock cycles per digit slot (legal >= 2)
GUARD, 2, blanked cycles at start of each slot (legal 0..SCAN_DIV-1)

Ports:
clk  input  1  system clock, all logic on rising edge
rst_n  input  1  reset, asynchronous assert, active-low
digits_in  input  4*NUM_DIGITS  BCD digits; nibble k = digit k, digit 0 = least significant
capture  input  1  load digits_in into the shadow register on this clock edge
seg_n  output  7  segments active-low; bit0=a … bit6=g
an_n  output  NUM_DIGITS  digit anodes active-low; bit k = digit k
bad_digit  output  1  high while any shadow digit > 9

Behaviour:
- Interface (already decided): one clock, clk; reset rst_n is asynchronous and active-low.
- Reset values: digit_q=0, tick_cnt=0, scan_idx=0, an_n=all 1, seg_n=7'h7F, bad_digit=0. All take effect immediately on rst_n low, including mid-slot.
- Capture:
  - capture=1 at an edge loads digit_q <= digits_in.
  - capture is level-sampled; holding it high reloads every cycle.
  - No effect on tick_cnt or scan_idx; a slot is never restarted.
- Prescaler:
  - tick_cnt counts 0..SCAN_DIV-1, then wraps to 0.
  - On that wrap, scan_idx increments modulo NUM_DIGITS: NUM_DIGITS-1 -> 0.
- Output register: one-cycle latency from (tick_cnt, scan_idx, digit_q) to (an_n, seg_n).
  - Guard: tick_cnt < GUARD -> an_n=all 1, seg_n=7'h7F.
  - Otherwise: an_n = one-cold at scan_idx; seg_n = ~pattern(digit_q[scan_idx]).
- Decode patterns, active-high gfedcba:
  - 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=6F
  - 10..15 = 40 (dash)
- bad_digit: registered OR over all digit_q nibbles > 9. Updates the cycle after the capture edge that changes digit_q.
- Output guarantees:
  - At most one an_n bit is low at any time.
  - an_n and seg_n never glitch between registered updates.
- NUM_DIGITS=1: scan_idx is held at 0; guard blanking still applies every slot.

Optional Feature:
- Macro: LEADING_ZERO_BLANK_EN.
- Defined:
  - Digit k > 0 is blanked when it and all higher digits equal 0.
  - Blanked means an_n all 1 and seg_n=7'h7F for that slot, with slot timing unchanged.
  - Digit 0 is never blanked.
  - Invalid digits count as non-zero.
- Undefined: every digit is always displayed, zeros included.

Test Plan:
(Bench parameters: NUM_DIGITS=4, SCAN_DIV=8, GUARD=2.)
1. Reset and first display: hold rst_n=0 for 3 clocks -> an_n=4'hF, seg_n=7'h7F, bad_digit=0. Release -> outputs stay blank through guard; then an_n=4'b1110, seg_n=7'h40 (digit 0 = "0").
2. Digit mapping: capture digits_in=16'h1234 -> slot 0: an_n=1110, seg_n=7'h19 ("4"). Slot 1: an_n=1101, seg_n=7'h30 ("3"). Check slots 2 and 3 likewise.
3. Wrap-around and slot timing: run 32 cycles -> scan_idx returns to 0. Each slot shows exactly 2 blank cycles then 6 driven cycles, with only one an_n bit ever low.
4. Invalid code: capture 16'h00A5 -> bad_digit=1 one cycle later; slot 1 seg_n=7'h3F (dash). Then capture 16'h0005 -> bad_digit=0 one cycle later.
5. Capture and reset mid-slot:
   - Capture 16'h0009 at tick_cnt=4 of slot 0 -> seg_n becomes 7'h10 the next cycle, no slot restart.
   - Assert rst_n=0 at tick_cnt=5 of slot 2 -> an_n=4'hF, seg_n=7'h7F immediately; digit_q cleared.
6. LEADING_ZERO_BLANK_EN:
   - Capture 16'h0042 -> slots 2 and 3 fully blank; slots 0 and 1 show "2" and "4".
   - Capture 16'h0000 -> only slot 0 drives, showing "0".
   - Repeat without the macro -> all four slots drive.
